// File: rtl/cache_fill_ctrl.sv
// Line-fill controller: fetches a missing line as NUM_BEATS beats, then writes it to the data array.
// Array writes appear one cycle after acceptance; the fill write takes priority and stalls stores for one cycle.
module cache_fill_ctrl #(
    parameter int NUM_WAYS         = 4,
    parameter int NUM_SETS         = 16,
    parameter int CACHE_LINE_BYTES = 64,
    parameter int BEAT_BYTES       = 16,
    parameter int ADDR_WIDTH       = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            miss_valid,
    output logic                            miss_ready,
    input  logic [ADDR_WIDTH-1:0]           miss_addr,
    input  logic [$clog2(NUM_WAYS)-1:0]     miss_way_idx,
    input  logic [$clog2(NUM_SETS)-1:0]     miss_set_idx,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic [ADDR_WIDTH-1:0]           mem_req_addr,
    input  logic                            mem_resp_valid,
    input  logic [BEAT_BYTES*8-1:0]         mem_resp_data,
    input  logic                            store_valid,
    output logic                            store_ready,
    input  logic [$clog2(NUM_WAYS)-1:0]     store_way_idx,
    input  logic [$clog2(NUM_SETS)-1:0]     store_set_idx,
    input  logic [CACHE_LINE_BYTES*8-1:0]   store_data,
    output logic                            update_en,
    output logic [$clog2(NUM_WAYS)-1:0]     update_way_idx,
    output logic [$clog2(NUM_SETS)-1:0]     update_set_idx,
    output logic [CACHE_LINE_BYTES*8-1:0]   update_data,
    output logic                            fill_done
);
    localparam int NUM_BEATS = CACHE_LINE_BYTES / BEAT_BYTES;
    localparam int LINE_BITS = CACHE_LINE_BYTES * 8;
    localparam int BEAT_BITS = BEAT_BYTES * 8;
    localparam int WL        = $clog2(NUM_WAYS);
    localparam int SL        = $clog2(NUM_SETS);
    localparam int OFS       = $clog2(CACHE_LINE_BYTES);
    localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, COLLECT, WRITE} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [WL-1:0]         way_q, way_d;
    logic [SL-1:0]         set_q, set_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_BITS-1:0]  line_q;
    logic                  beat_wr;
    logic                  upd_en_q, upd_en_d;
    logic [WL-1:0]         upd_way_q, upd_way_d;
    logic [SL-1:0]         upd_set_q, upd_set_d;
    logic [LINE_BITS-1:0]  upd_data_q, upd_data_d;
    logic                  fill_done_q, fill_done_d;
    logic                  unused_ofs;

    // Byte offset within the line never reaches memory.
    assign unused_ofs = ^miss_addr[OFS-1:0];

    assign miss_ready     = (state_q == IDLE);
    assign store_ready    = (state_q != WRITE);
    assign mem_req_valid  = (state_q == REQ);
    assign mem_req_addr   = addr_q;
    assign update_en      = upd_en_q;
    assign update_way_idx = upd_way_q;
    assign update_set_idx = upd_set_q;
    assign update_data    = upd_data_q;
    assign fill_done      = fill_done_q;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        way_d       = way_q;
        set_d       = set_q;
        addr_d      = addr_q;
        beat_wr     = 1'b0;
        upd_en_d    = 1'b0;
        fill_done_d = 1'b0;
        upd_way_d   = upd_way_q;
        upd_set_d   = upd_set_q;
        upd_data_d  = upd_data_q;
        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    way_d   = miss_way_idx;
                    set_d   = miss_set_idx;
                    addr_d  = {miss_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (mem_resp_valid) begin
                    beat_wr = 1'b1;
                    if (beat_q == BW'(NUM_BEATS - 1)) begin
                        beat_d  = '0;
                        state_d = WRITE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                upd_en_d    = 1'b1;
                fill_done_d = 1'b1;
                upd_way_d   = way_q;
                upd_set_d   = set_q;
                upd_data_d  = line_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // store_ready is low in WRITE, so a store never collides with the fill write.
        if (store_valid && state_q != WRITE) begin
            upd_en_d   = 1'b1;
            upd_way_d  = store_way_idx;
            upd_set_d  = store_set_idx;
            upd_data_d = store_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            way_q       <= '0;
            set_q       <= '0;
            addr_q      <= '0;
            upd_en_q    <= 1'b0;
            upd_way_q   <= '0;
            upd_set_q   <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            way_q       <= way_d;
            set_q       <= set_d;
            addr_q      <= addr_d;
            upd_en_q    <= upd_en_d;
            upd_way_q   <= upd_way_d;
            upd_set_q   <= upd_set_d;
            fill_done_q <= fill_done_d;
        end
    end

    // Data paths are left unreset; every beat slot is rewritten before a fill uses it.
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            line_q[int'(beat_q)*BEAT_BITS +: BEAT_BITS] <= mem_resp_data;
        end
        upd_data_q <= upd_data_d;
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed scenarios with randomized data/stores, checked each cycle against a transaction-level model.
module tb_cache_fill_ctrl;
    localparam int NB = 4;
    localparam int LB = 512;
    localparam int BB = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           miss_valid, miss_ready;
    logic [31:0]    miss_addr;
    logic [1:0]     miss_way_idx;
    logic [3:0]     miss_set_idx;
    logic           mem_req_valid, mem_req_ready;
    logic [31:0]    mem_req_addr;
    logic           mem_resp_valid;
    logic [BB-1:0]  mem_resp_data;
    logic           store_valid, store_ready;
    logic [1:0]     store_way_idx;
    logic [3:0]     store_set_idx;
    logic [LB-1:0]  store_data;
    logic           update_en;
    logic [1:0]     update_way_idx;
    logic [3:0]     update_set_idx;
    logic [LB-1:0]  update_data;
    logic           fill_done;

    cache_fill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .miss_way_idx(miss_way_idx), .miss_set_idx(miss_set_idx),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .store_valid(store_valid), .store_ready(store_ready),
        .store_way_idx(store_way_idx), .store_set_idx(store_set_idx), .store_data(store_data),
        .update_en(update_en), .update_way_idx(update_way_idx), .update_set_idx(update_set_idx),
        .update_data(update_data), .fill_done(fill_done)
    );

    int checks = 0;
    int errors = 0;
    int store_mode = 0;   // 0: stores untouched, 1: store every cycle, 2: random stores

    // Transaction-level model of the outstanding fill
    bit            m_busy;
    bit            m_reqd;
    int            m_beats;
    logic [1:0]    m_way;
    logic [3:0]    m_set;
    logic [31:0]   m_addr;
    logic [LB-1:0] m_line;

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] r;
        for (int i = 0; i < LB/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [BB-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_reqd = 0; m_beats = 0;
        m_way = '0; m_set = '0; m_addr = '0;
    endtask

    // One clock: check state-dependent outputs, predict the array write, advance model, check after edge.
    task automatic step();
        bit            wph;
        logic          pen, pdone;
        logic [1:0]    pway;
        logic [3:0]    pset;
        logic [LB-1:0] pdata;
        if (store_mode != 0) begin
            store_valid   = (store_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            store_way_idx = 2'($urandom);
            store_set_idx = 4'($urandom);
            store_data    = rand_line();
        end
        wph = m_busy && (m_beats == NB);
        chk("miss_ready",    LB'(miss_ready),    LB'(!m_busy));
        chk("mem_req_valid", LB'(mem_req_valid), LB'(m_busy && !m_reqd));
        chk("mem_req_addr",  LB'(mem_req_addr),  LB'(m_addr));
        chk("store_ready",   LB'(store_ready),   LB'(!wph));
        pen = 0; pdone = 0; pway = '0; pset = '0; pdata = '0;
        if (wph) begin
            pen = 1; pdone = 1; pway = m_way; pset = m_set; pdata = m_line;
        end else if (store_valid) begin
            pen = 1; pway = store_way_idx; pset = store_set_idx; pdata = store_data;
        end
        if (!m_busy) begin
            if (miss_valid) begin
                m_busy = 1; m_reqd = 0; m_beats = 0;
                m_way = miss_way_idx; m_set = miss_set_idx;
                m_addr = miss_addr & ~32'h3F;
            end
        end else if (!m_reqd) begin
            if (mem_req_ready) m_reqd = 1;
        end else if (m_beats < NB) begin
            if (mem_resp_valid) begin
                m_line[m_beats*BB +: BB] = mem_resp_data;
                m_beats++;
            end
        end else begin
            m_busy = 0;
        end
        @(posedge clk); #1;
        chk("update_en", LB'(update_en), LB'(pen));
        chk("fill_done", LB'(fill_done), LB'(pdone));
        if (pen) begin
            chk("update_way_idx", LB'(update_way_idx), LB'(pway));
            chk("update_set_idx", LB'(update_set_idx), LB'(pset));
            chk("update_data",    update_data,         pdata);
        end
    endtask

    task automatic do_fill(input logic [31:0] addr, input logic [1:0] way, input logic [3:0] set,
                           input int rdy_wait, input int gap, input bit pat,
                           input bit hold, input logic [31:0] naddr, input logic [1:0] nway,
                           input logic [3:0] nset);
        logic [3:0] nib;
        miss_valid = 1; miss_addr = addr; miss_way_idx = way; miss_set_idx = set;
        mem_req_ready = 0; mem_resp_valid = 0;
        step();
        miss_valid = 0; miss_addr = $urandom; miss_way_idx = 2'($urandom); miss_set_idx = 4'($urandom);
        for (int i = 0; i < rdy_wait; i++) begin
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_data  = rand_beat();
            step();
        end
        mem_req_ready = 1; mem_resp_valid = 0;
        step();
        mem_req_ready = 0;
        if (hold) begin
            miss_valid = 1; miss_addr = naddr; miss_way_idx = nway; miss_set_idx = nset;
        end
        for (int b = 0; b < NB; b++) begin
            for (int g = 0; g < gap; g++) begin
                mem_resp_valid = 0;
                mem_resp_data  = rand_beat();
                step();
            end
            nib = 4'hA + 4'(b);
            mem_resp_valid = 1;
            mem_resp_data  = pat ? {32{nib}} : rand_beat();
            step();
        end
        mem_resp_valid = 0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a2;
        logic [1:0]  w2;
        logic [3:0]  s2;
        rst_n = 0;
        miss_valid = 0; miss_addr = '0; miss_way_idx = '0; miss_set_idx = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        store_valid = 0; store_way_idx = '0; store_set_idx = '0; store_data = '0;
        model_reset();
        m_line = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst update_en",     LB'(update_en),     LB'(0));
        chk("rst fill_done",     LB'(fill_done),     LB'(0));
        chk("rst mem_req_valid", LB'(mem_req_valid), LB'(0));
        chk("rst miss_ready",    LB'(miss_ready),    LB'(1));
        chk("rst mem_req_addr",  LB'(mem_req_addr),  LB'(0));
        rst_n = 1;

        // Basic fill with fixed beat patterns; line address 0x1200
        do_fill(32'h0000_1234, 2'd2, 4'd5, 0, 0, 1, 0, '0, '0, '0);
        chk("fill line pattern", m_line, {{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}});

        // Request held off three cycles, stray beats during REQ
        do_fill($urandom, 2'($urandom), 4'($urandom), 3, 0, 0, 0, '0, '0, '0);

        // Continuous stores across a whole fill
        store_mode = 1;
        do_fill($urandom, 2'($urandom), 4'($urandom), 1, 1, 0, 0, '0, '0, '0);
        store_mode = 0; store_valid = 0;

        // Second miss pending during COLLECT
        a2 = $urandom; w2 = 2'($urandom); s2 = 4'($urandom);
        do_fill($urandom, 2'($urandom), 4'($urandom), 0, 1, 0, 1, a2, w2, s2);
        do_fill(a2, w2, s2, 0, 0, 0, 0, '0, '0, '0);

        // Reset after two of four beats, beats keep arriving
        miss_valid = 1; miss_addr = $urandom; miss_way_idx = 2'($urandom); miss_set_idx = 4'($urandom);
        step();
        miss_valid = 0; mem_req_ready = 1;
        step();
        mem_req_ready = 0; mem_resp_valid = 1;
        for (int i = 0; i < 2; i++) begin
            mem_resp_data = rand_beat();
            step();
        end
        rst_n = 0;
        #1;
        model_reset();
        chk("midrst update_en",     LB'(update_en),     LB'(0));
        chk("midrst fill_done",     LB'(fill_done),     LB'(0));
        chk("midrst mem_req_valid", LB'(mem_req_valid), LB'(0));
        chk("midrst miss_ready",    LB'(miss_ready),    LB'(1));
        chk("midrst mem_req_addr",  LB'(mem_req_addr),  LB'(0));
        #2;
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            mem_resp_data = rand_beat();
            step();
        end
        mem_resp_valid = 0;
        do_fill($urandom, 2'($urandom), 4'($urandom), 0, 0, 0, 0, '0, '0, '0);

        // Response pulses while idle, then a fill with two-cycle gaps
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1; mem_resp_data = rand_beat();
            step();
        end
        mem_resp_valid = 0;
        do_fill($urandom, 2'($urandom), 4'($urandom), 0, 2, 0, 0, '0, '0, '0);

        // Randomized fills with random interleaved stores
        store_mode = 2;
        for (int n = 0; n < 8; n++) begin
            do_fill($urandom, 2'($urandom), 4'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, 2), 0, 0, '0, '0, '0);
        end
        store_mode = 0; store_valid = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameters, with defaults: NUM_WAYS = 4 (ways in data array); NUM_SETS = 16 (sets per way); CACHE_LINE_BYTES = 64 (line size); BEAT_BYTES = 16 (memory response beat size); ADDR_WIDTH = 32 (byte address width).
REQ-002 Derived values: NUM_BEATS = CACHE_LINE_BYTES/BEAT_BYTES; LINE_BITS = CACHE_LINE_BYTES*8; BEAT_BITS = BEAT_BYTES*8; WL = $clog2(NUM_WAYS); SL = $clog2(NUM_SETS); OFS = $clog2(CACHE_LINE_BYTES).
REQ-003 Ports, in the form name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- miss_valid, in, 1, fill request.
- miss_ready, out, 1, fill request accepted.
- miss_addr, in, ADDR_WIDTH, missing byte address.
- miss_way_idx, in, WL, victim way.
- miss_set_idx, in, SL, target set.
- mem_req_valid, out, 1, memory read request.
- mem_req_ready, in, 1, memory accepts request.
- mem_req_addr, out, ADDR_WIDTH, line-aligned address.
- mem_resp_valid, in, 1, response beat valid (no backpressure).
- mem_resp_data, in, BEAT_BITS, beat payload.
- store_valid, in, 1, full-line store request.
- store_ready, out, 1, store accepted.
- store_way_idx, in, WL, store way.
- store_set_idx, in, SL, store set.
- store_data, in, LINE_BITS, store line data.
- update_en, out, 1, data-array write strobe.
- update_way_idx, out, WL, data-array write way.
- update_set_idx, out, SL, data-array write set.
- update_data, out, LINE_BITS, data-array write data.
- fill_done, out, 1, one-cycle pulse when a fill line is written.

Function
REQ-004 The FSM SHALL have four states: IDLE, REQ, COLLECT and WRITE.
REQ-005 miss_ready SHALL equal (state==IDLE); on miss_valid&&miss_ready the block SHALL latch way, set and {miss_addr[ADDR_WIDTH-1:OFS], OFS'b0}, then enter REQ.
REQ-006 In REQ, mem_req_valid SHALL be 1 and mem_req_addr SHALL hold the latched line address stable; on mem_req_ready the FSM SHALL enter COLLECT with beat counter = 0.
REQ-007 In COLLECT, each mem_resp_valid SHALL write mem_resp_data into line buffer bits [k*BEAT_BITS +: BEAT_BITS], where k is the beat counter, and increment k.
REQ-008 When beat NUM_BEATS-1 is received, the counter SHALL wrap to 0 and the FSM SHALL enter WRITE.
REQ-009 mem_resp_valid outside COLLECT SHALL be ignored; gaps between beats SHALL be tolerated.
REQ-010 WRITE SHALL last exactly one cycle and then return to IDLE; a new miss SHALL be acceptable the following cycle.
REQ-011 The update_* outputs and fill_done SHALL be registered; update_en SHALL be 0 in any cycle without a write.
REQ-012 Fill write: the cycle after WRITE, the block SHALL drive update_en=1 with the latched way and set, update_data = line buffer, and fill_done=1.
REQ-013 store_ready SHALL equal (state!=WRITE), so the fill has priority and stores stall exactly one cycle.
REQ-014 Store write: for store_valid&&store_ready in cycle N, cycle N+1 SHALL carry update_en=1 with the store's way, set and data, and fill_done=0.
REQ-015 Stores SHALL be accepted in IDLE, REQ and COLLECT, interleaved with an in-progress fill.
REQ-016 No set/way hazard check SHALL be performed: a store to the line being filled is overwritten by the later fill write.
REQ-017 miss_valid while not IDLE SHALL not be accepted and SHALL cause no state change.

Reset
REQ-018 On rst_n low, asynchronously: state=IDLE, beat counter=0, update_en=0, fill_done=0, mem_req_valid=0, and latched way/set/address=0.
REQ-019 The line buffer and update_data SHALL not be reset.
REQ-020 Reset mid-fill SHALL discard collected beats; any beats arriving after reset SHALL be ignored because state is IDLE.

Verification
REQ-021 Miss at address 0x0000_1234, way 2, set 5, mem_req_ready=1, four beats 0xA..,0xB..,0xC..,0xD.. -> mem_req_addr=0x0000_1200; update_en with way 2, set 5, data {D,C,B,A} (A lowest); fill_done single pulse.
REQ-022 mem_req_ready held low 3 cycles -> mem_req_valid and mem_req_addr stable all 3 cycles; no beat captured before acceptance.
REQ-023 store_valid held continuously during a fill -> one store write per cycle except the cycle after WRITE, which carries the fill write; no store lost or duplicated.
REQ-024 Second miss_valid asserted during COLLECT -> miss_ready=0 until after WRITE; second fill then proceeds normally with its own way and set.
REQ-025 rst_n low after beat 2 of 4 -> all outputs at reset values immediately; next fill assembles only new beats, with no stale data in any beat position.
REQ-026 Beats with 2-cycle gaps plus mem_resp_valid pulsed in IDLE -> IDLE pulses ignored; line assembled correctly.
